// File: rtl/id_imm_sequencer_if.sv
// id_imm_sequencer_if: upstream/downstream valid-ready bundle for the decode-stage immediate sequencer.
// W is the PC width and must equal 1<<(XLEN+4) of the attached sequencer.
interface id_imm_sequencer_if #(
  parameter int unsigned W = 64
);
  logic          i_flush;
  logic          i_if_valid;
  logic          o_if_ready;
  logic [31:0]   i_instr;
  logic [W-1:0]  i_pc;
  logic          o_id_valid;
  logic          i_id_ready;
  logic [2:0]    o_imm_ctl;
  logic          o_sign_ext;
  logic [24:0]   o_instr_bits;
  logic [W-1:0]  o_pc;
  logic          o_illegal;

  modport slave (
    input  i_flush, i_if_valid, i_instr, i_pc, i_id_ready,
    output o_if_ready, o_id_valid, o_imm_ctl, o_sign_ext, o_instr_bits, o_pc, o_illegal
  );

  modport master (
    output i_flush, i_if_valid, i_instr, i_pc, i_id_ready,
    input  o_if_ready, o_id_valid, o_imm_ctl, o_sign_ext, o_instr_bits, o_pc, o_illegal
  );
endinterface

// File: rtl/id_imm_sequencer.sv
// id_imm_sequencer: classifies fetched instructions into Imm_32 generator controls behind a 2-entry skid buffer.
// Optional feature: define ID_ILLEGAL_DETECT_EN to store and report a per-entry unrecognised-opcode flag.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module id_imm_sequencer #(
  parameter int unsigned XLEN = `XLEN_64b
) (
  input logic               i_clk,
  input logic               i_rst,
  id_imm_sequencer_if.slave bus
);
  localparam int unsigned W = 1 << (XLEN + 4);

  localparam logic [2:0] IMM_I_TYPE = 3'd0;
  localparam logic [2:0] IMM_S_TYPE = 3'd1;
  localparam logic [2:0] IMM_B_TYPE = 3'd2;
  localparam logic [2:0] IMM_J_TYPE = 3'd3;
  localparam logic [2:0] IMM_U_TYPE = 3'd4;
  localparam logic [2:0] IMM_NONE   = 3'b111;

  localparam logic [6:0] OP_OP   = 7'b0110011;
  localparam logic [6:0] OP_OP32 = 7'b0111011;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef struct packed {
    logic [2:0]   ctl;
    logic         sext;
    logic [24:0]  bits;
    logic [W-1:0] pc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{ctl: IMM_NONE, sext: 1'b1, bits: '0, pc: '0};

  state_t     r_state, w_state_n;
  logic       r_if_ready;
  entry_t     r_main, r_skid, w_dec;
  logic [6:0] w_op;
  logic       w_push, w_pop;
  logic       w_main_ld_in, w_main_ld_skid, w_main_clr, w_skid_ld;

  assign w_op = bus.i_instr[6:0];

  always_comb begin
    w_dec.ctl  = IMM_NONE;
    w_dec.sext = 1'b1;
    w_dec.bits = bus.i_instr[31:7];
    w_dec.pc   = bus.i_pc;
    case (w_op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: w_dec.ctl = IMM_I_TYPE;
      7'b1110011: begin
        w_dec.ctl  = IMM_I_TYPE;
        w_dec.sext = ~bus.i_instr[14]; // CSR*I forms carry an unsigned zimm
      end
      7'b0011011: if (XLEN == `XLEN_64b) w_dec.ctl = IMM_I_TYPE;
      7'b0100011: w_dec.ctl = IMM_S_TYPE;
      7'b1100011: w_dec.ctl = IMM_B_TYPE;
      7'b1101111: w_dec.ctl = IMM_J_TYPE;
      7'b0110111, 7'b0010111: w_dec.ctl = IMM_U_TYPE;
      default: ;
    endcase
  end

  assign w_push = bus.i_if_valid & r_if_ready;
  assign w_pop  = bus.o_id_valid & bus.i_id_ready;

  always_comb begin
    w_state_n      = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    if (bus.i_flush) begin
      w_state_n  = S_EMPTY;
      w_main_clr = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) begin
          w_state_n    = S_ONE;
          w_main_ld_in = 1'b1;
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_ld_in = 1'b1;
          end else if (w_push) begin
            w_state_n = S_TWO;
            w_skid_ld = 1'b1;
          end else if (w_pop) begin
            w_state_n  = S_EMPTY;
            w_main_clr = 1'b1;
          end
        end
        S_TWO: if (w_pop) begin
          w_state_n      = S_ONE;
          w_main_ld_skid = 1'b1;
        end
        default: begin
          w_state_n  = S_EMPTY;
          w_main_clr = 1'b1;
        end
      endcase
    end
  end

  // Main is cleared on every transition to EMPTY so idle outputs show reset values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_EMPTY;
      r_if_ready <= 1'b1;
      r_main     <= ENTRY_RST;
      r_skid     <= ENTRY_RST;
    end else begin
      r_state    <= w_state_n;
      r_if_ready <= (w_state_n != S_TWO);
      if (w_main_ld_in)        r_main <= w_dec;
      else if (w_main_ld_skid) r_main <= r_skid;
      else if (w_main_clr)     r_main <= ENTRY_RST;
      if (w_skid_ld)           r_skid <= w_dec;
    end
  end

  assign bus.o_if_ready   = r_if_ready;
  assign bus.o_id_valid   = (r_state != S_EMPTY);
  assign bus.o_imm_ctl    = r_main.ctl;
  assign bus.o_sign_ext   = r_main.sext;
  assign bus.o_instr_bits = r_main.bits;
  assign bus.o_pc         = r_main.pc;

`ifdef ID_ILLEGAL_DETECT_EN
  logic w_dec_ill, r_main_ill, r_skid_ill;

  // No immediate is legitimate only for OP, and OP-32 on 64-bit builds.
  assign w_dec_ill = (w_dec.ctl == IMM_NONE) && (w_op != OP_OP) &&
                     !((w_op == OP_OP32) && (XLEN == `XLEN_64b));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_main_ld_in)        r_main_ill <= w_dec_ill;
      else if (w_main_ld_skid) r_main_ill <= r_skid_ill;
      else if (w_main_clr)     r_main_ill <= 1'b0;
      if (w_skid_ld)           r_skid_ill <= w_dec_ill;
    end
  end

  assign bus.o_illegal = r_main_ill & bus.o_id_valid;
`else
  assign bus.o_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_id_imm_sequencer.sv
// tb_id_imm_sequencer: directed checks of decode, skid buffering, flush and reset for id_imm_sequencer.
// A 32-bit instance is included for the OP-IMM-32 legality case.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module tb_id_imm_sequencer;
  localparam logic [2:0] I_T = 3'd0, S_T = 3'd1, B_T = 3'd2, J_T = 3'd3, U_T = 3'd4, NO = 3'b111;
`ifdef ID_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [95:0] e, g;
  logic [4:0]  e32, g32;

  id_imm_sequencer_if #(.W(64)) b64 ();
  id_imm_sequencer_if #(.W(32)) b32 ();

  id_imm_sequencer #(.XLEN(`XLEN_64b)) dut64 (.i_clk(clk), .i_rst(rst), .bus(b64.slave));
  id_imm_sequencer #(.XLEN(`XLEN_32b)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));

  always #5 clk = ~clk;

  function automatic logic [95:0] mk(bit v, bit r, logic [2:0] c, bit s, bit il,
                                     logic [24:0] b, logic [63:0] p);
    return {v, r, c, s, il, b, p};
  endfunction

  function automatic logic [95:0] snap();
    return {b64.o_id_valid, b64.o_if_ready, b64.o_imm_ctl, b64.o_sign_ext, b64.o_illegal,
            b64.o_instr_bits, b64.o_pc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] ins, logic [63:0] pc);
    b64.i_if_valid = v;
    b64.i_instr    = ins;
    b64.i_pc       = pc;
  endtask

  task automatic test_reset();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_idle: got %h exp %h", g, e); end
    b64.i_id_ready = 1'b0;
    drive(1, 32'h00000013, 64'h10); cyc();
    drive(1, 32'h00000063, 64'h14); cyc();
    g = snap(); e = mk(1, 0, I_T, 1, 0, 0, 64'h10); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_prefill: got %h exp %h", g, e); end
    rst = 1'b1;
    drive(1, 32'h00000037, 64'h18); cyc();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_cycle1: got %h exp %h", g, e); end
    cyc();
    g = snap(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_cycle2: got %h exp %h", g, e); end
    rst = 1'b0;
    drive(0, 0, 0);
    b64.i_id_ready = 1'b1;
    cyc();
    g = snap(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_after: got %h exp %h", g, e); end
  endtask

  task automatic test_stream();
    b64.i_id_ready = 1'b1;
    drive(1, 32'hFFF00093, 64'h100); cyc();
    g = snap(); e = mk(1, 1, I_T, 1, 0, 25'h1FFE001, 64'h100); checks++;
    if (g !== e) begin errors++; $display("FAIL stream_addi: got %h exp %h", g, e); end
    drive(1, 32'h00112023, 64'h104); cyc();
    g = snap(); e = mk(1, 1, S_T, 1, 0, 25'h0002240, 64'h104); checks++;
    if (g !== e) begin errors++; $display("FAIL stream_sw: got %h exp %h", g, e); end
    drive(1, 32'h0000006F, 64'h108); cyc();
    g = snap(); e = mk(1, 1, J_T, 1, 0, 0, 64'h108); checks++;
    if (g !== e) begin errors++; $display("FAIL stream_jal: got %h exp %h", g, e); end
    drive(0, 0, 0); cyc();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL stream_drain: got %h exp %h", g, e); end
  endtask

  task automatic test_backpressure();
    b64.i_id_ready = 1'b0;
    drive(1, 32'h00000013, 64'h200); cyc();
    g = snap(); e = mk(1, 1, I_T, 1, 0, 0, 64'h200); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_one: got %h exp %h", g, e); end
    drive(1, 32'h00000063, 64'h204); cyc();
    g = snap(); e = mk(1, 0, I_T, 1, 0, 0, 64'h200); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_two: got %h exp %h", g, e); end
    drive(1, 32'h00000037, 64'h208); cyc();
    g = snap(); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_hold: got %h exp %h", g, e); end
    b64.i_id_ready = 1'b1; cyc();
    g = snap(); e = mk(1, 1, B_T, 1, 0, 0, 64'h204); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_skid_out: got %h exp %h", g, e); end
    cyc();
    g = snap(); e = mk(1, 1, U_T, 1, 0, 0, 64'h208); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_third: got %h exp %h", g, e); end
    drive(0, 0, 0); cyc();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL bp_empty: got %h exp %h", g, e); end
  endtask

  task automatic test_csr();
    b64.i_id_ready = 1'b1;
    drive(1, 32'h0052D073, 64'h300); cyc();
    g = snap(); e = mk(1, 1, I_T, 0, 0, 25'h000A5A0, 64'h300); checks++;
    if (g !== e) begin errors++; $display("FAIL csr_csrrwi: got %h exp %h", g, e); end
    drive(1, 32'h34011073, 64'h304); cyc();
    g = snap(); e = mk(1, 1, I_T, 1, 0, 25'h0680220, 64'h304); checks++;
    if (g !== e) begin errors++; $display("FAIL csr_csrrw: got %h exp %h", g, e); end
    drive(1, 32'h00000033, 64'h308); cyc();
    g = snap(); e = mk(1, 1, NO, 1, 0, 0, 64'h308); checks++;
    if (g !== e) begin errors++; $display("FAIL csr_add: got %h exp %h", g, e); end
    drive(1, 32'h0000003B, 64'h30C); cyc();
    g = snap(); e = mk(1, 1, NO, 1, 0, 0, 64'h30C); checks++;
    if (g !== e) begin errors++; $display("FAIL op32_64b: got %h exp %h", g, e); end
    drive(1, 32'h0000001B, 64'h310); cyc();
    g = snap(); e = mk(1, 1, I_T, 1, 0, 0, 64'h310); checks++;
    if (g !== e) begin errors++; $display("FAIL opimm32_64b: got %h exp %h", g, e); end
    drive(0, 0, 0); cyc();
  endtask

  task automatic test_flush();
    b64.i_id_ready = 1'b0;
    drive(1, 32'h00000013, 64'h400); cyc();
    drive(1, 32'h00000023, 64'h404); cyc();
    g = snap(); e = mk(1, 0, I_T, 1, 0, 0, 64'h400); checks++;
    if (g !== e) begin errors++; $display("FAIL flush_prefill: got %h exp %h", g, e); end
    b64.i_flush = 1'b1;
    drive(1, 32'h00000017, 64'h408); cyc();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL flush_empty: got %h exp %h", g, e); end
    b64.i_flush = 1'b0;
    b64.i_id_ready = 1'b1;
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL flush_no_ghost%0d: got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_illegal();
    b64.i_id_ready = 1'b1;
    b32.i_id_ready = 1'b1;
    drive(1, 32'h0000007F, 64'h500); cyc();
    g = snap(); e = mk(1, 1, NO, 1, ILL_EN, 0, 64'h500); checks++;
    if (g !== e) begin errors++; $display("FAIL illegal_7f: got %h exp %h", g, e); end
    drive(0, 0, 0);
    b32.i_if_valid = 1'b1; b32.i_instr = 32'h0000001B; b32.i_pc = 32'h600;
    cyc();
    g = snap(); e = mk(0, 1, NO, 1, 0, 0, 0); checks++;
    if (g !== e) begin errors++; $display("FAIL illegal_clear: got %h exp %h", g, e); end
    g32 = {b32.o_id_valid, b32.o_imm_ctl, b32.o_illegal}; e32 = {1'b1, NO, ILL_EN}; checks++;
    if (g32 !== e32) begin errors++; $display("FAIL illegal_opimm32_32b: got %h exp %h", g32, e32); end
    b32.i_instr = 32'h00000013; b32.i_pc = 32'h604;
    cyc();
    g32 = {b32.o_id_valid, b32.o_imm_ctl, b32.o_illegal}; e32 = {1'b1, I_T, 1'b0}; checks++;
    if (g32 !== e32) begin errors++; $display("FAIL legal_opimm_32b: got %h exp %h", g32, e32); end
    b32.i_if_valid = 1'b0;
    cyc();
    g32 = {b32.o_id_valid, b32.o_imm_ctl, b32.o_illegal}; e32 = {1'b0, NO, 1'b0}; checks++;
    if (g32 !== e32) begin errors++; $display("FAIL empty_32b: got %h exp %h", g32, e32); end
  endtask

  initial begin
    b64.i_flush = 1'b0; b64.i_id_ready = 1'b1;
    drive(0, 0, 0);
    b32.i_flush = 1'b0; b32.i_if_valid = 1'b0; b32.i_instr = '0; b32.i_pc = '0; b32.i_id_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    test_reset();
    test_stream();
    test_backpressure();
    test_csr();
    test_flush();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
